mux8_1_tdm: RTL and testbench

Time-division multiplexer that serializes eight parallel data lanes onto the single-bit `d`/`e`/`s[2:0]` link consumed by the 1-to-8 enabled demultiplexer at the far end. One `start` pulse captures a frame of eight lane bits and presents them one per clock, with the lane index on `s` and `e` high while a bit is valid. A `busy`/`done` handshake lets the upstream controller pace frames back to back.

---
 rtl/mux8_1_tdm.sv | 106 ++++++++++
 tb/tb_mux8_1_tdm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mux8_1_tdm.sv
// Eight-lane to single-bit TDM serializer: one start pulse sends a captured frame lane by lane on d/e/s.
// Optional MUX8_SKIP_EN: lanes whose captured v bit is 0 are skipped; otherwise all eight lanes are sent.
module mux8_1_tdm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x,
  input  logic [7:0] v,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       d,
  output logic       e,
  output logic [2:0] s
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic [7:0] xr_q, xr_d;
  logic [7:0] vr_q, vr_d;
  logic [2:0] s_q, s_d;
  logic       d_q, d_d;
  logic       done_q, done_d;
  logic [7:0] v_eff;
  logic [3:0] seek_first, seek_next;

`ifdef MUX8_SKIP_EN
  assign v_eff = v;
`else
  logic unused_v;
  assign unused_v = ^v;
  assign v_eff    = 8'hFF;
`endif

  // Lowest set bit of mask at index >= lo; returns {found, index}.
  function automatic logic [3:0] seek(input logic [7:0] mask, input logic [3:0] lo);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if ((4'(i) >= lo) && mask[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign seek_first = seek(v_eff, 4'd0);
  assign seek_next  = seek(vr_q, {1'b0, s_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    vr_d    = vr_q;
    s_d     = 3'd0;
    d_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          xr_d = x;
          vr_d = v_eff;
          if (seek_first[3]) begin
            state_d = SEND;
            s_d     = seek_first[2:0];
            d_d     = x[seek_first[2:0]];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (seek_next[3]) begin
          s_d = seek_next[2:0];
          d_d = xr_q[seek_next[2:0]];
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= 8'h00;
      vr_q    <= 8'h00;
      s_q     <= 3'd0;
      d_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      vr_q    <= vr_d;
      s_q     <= s_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SEND);
  assign e    = (state_q == SEND);
  assign s    = s_q;
  assign d    = d_q;
  assign done = done_q;

endmodule

// File: tb/tb_mux8_1_tdm.sv
// Directed bench for mux8_1_tdm: expected per-cycle link state is queued when a frame is requested.
module tb_mux8_1_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] v;
  logic       start;
  logic       busy, done, d, e;
  logic [2:0] s;

  // Expected word layout: {busy, done, e, s[2:0], d}
  logic [6:0] q[$];
  int n_vec;
  int n_err;

  localparam logic [6:0] IDLE_W = 7'b0000000;
  localparam logic [6:0] DONE_W = 7'b0100000;

  mux8_1_tdm dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .v    (v),
    .start(start),
    .busy (busy),
    .done (done),
    .d    (d),
    .e    (e),
    .s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {busy, done, e, s, d};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed={b%0b dn%0b e%0b s%0d d%0b} expected={b%0b dn%0b e%0b s%0d d%0b}",
             tag, obs[6], obs[5], obs[4], obs[3:1], obs[0],
             exp[6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  task automatic cyc(input string tag);
    logic [6:0] exp;
    @(posedge clk);
    #1;
    exp = (q.size() != 0) ? q.pop_front() : IDLE_W;
    check(tag, exp);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      cyc(tag);
      guard++;
    end
    cyc({tag, "_idle"});
    cyc({tag, "_idle"});
  endtask

  // Queue the link words a frame of data xv with mask vv must produce.
  task automatic push_frame(input logic [7:0] xv, input logic [7:0] vv);
    logic [7:0] m;
`ifdef MUX8_SKIP_EN
    m = vv;
`else
    m = 8'hFF;
    if (vv == 8'h5A) m = 8'hFF;
`endif
    for (int i = 0; i < 8; i++) begin
      if (m[i]) q.push_back({1'b1, 1'b0, 1'b1, 3'(i), xv[i]});
    end
    q.push_back(DONE_W);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    x     = 8'hFF;
    v     = 8'hFF;
    start = 1'b0;

    // Reset held with input activity.
    for (int i = 0; i < 4; i++) begin
      x     = ~x;
      start = i[0];
      cyc("reset_idle");
    end
    start = 1'b0;
    rst_n = 1'b1;
    cyc("post_reset_idle");

    // Single frame with a start pulse mid-frame that must be ignored.
    x = 8'hA5; v = 8'hFF; start = 1'b1;
    push_frame(8'hA5, 8'hFF);
    cyc("a5_frame");
    start = 1'b0;
    cyc("a5_frame");
    cyc("a5_frame");
    start = 1'b1; x = 8'h00;
    cyc("a5_frame");
    start = 1'b0;
    drain("a5_frame");

    // Back-to-back frames with start held high.
    x = 8'h0F; start = 1'b1;
    push_frame(8'h0F, 8'hFF);
    for (int i = 0; i < 9; i++) cyc("b2b_first");
    x = 8'hF0;
    push_frame(8'hF0, 8'hFF);
    cyc("b2b_second");
    start = 1'b0;
    x = 8'h00;
    drain("b2b_second");

    // Asynchronous reset while s=3.
    x = 8'h3C; start = 1'b1;
    push_frame(8'h3C, 8'hFF);
    cyc("pre_rst_frame");
    start = 1'b0;
    cyc("pre_rst_frame");
    cyc("pre_rst_frame");
    cyc("pre_rst_frame");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", IDLE_W);
    q.delete();
    cyc("in_reset");
    cyc("in_reset_no_done");
    rst_n = 1'b1;
    x = 8'h5A; start = 1'b1;
    push_frame(8'h5A, 8'hFF);
    cyc("after_reset_frame");
    start = 1'b0;
    drain("after_reset_frame");

    // Shadow capture: x changes right after start.
    x = 8'h01; start = 1'b1;
    push_frame(8'h01, 8'hFF);
    cyc("shadow");
    start = 1'b0;
    x = 8'hFE;
    drain("shadow");

`ifdef MUX8_SKIP_EN
    x = 8'hFF; v = 8'b1000_0101; start = 1'b1;
    push_frame(8'hFF, 8'b1000_0101);
    cyc("skip_sparse");
    start = 1'b0; v = 8'hFF;
    drain("skip_sparse");

    x = 8'hFF; v = 8'h00; start = 1'b1;
    push_frame(8'hFF, 8'h00);
    cyc("skip_empty");
    start = 1'b0; v = 8'hFF;
    drain("skip_empty");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
